// File: rtl/dcache_memctrl.sv
// Burst sequencer between the dcache memory port and a single-word memory bus.
// A line burst is split into CACHEWORDS word commands, starting at the requested
// word and wrapping within the line. Read returns are forwarded one cycle later.
module dcache_memctrl #(
    parameter int ADDRBITS      = 32,
    parameter int DATABITS      = 32,
    parameter int CACHEWORDS    = 32,
    parameter int CACHEADDRBITS = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDRBITS-1:0] mem_addr,
    input  logic                mem_rdreq,
    input  logic                mem_wrreq,
    input  logic [DATABITS-1:0] mem_datain,
    output logic [DATABITS-1:0] mem_out,
    output logic                mem_valid,
    output logic                mem_wrack,
    output logic [15:0]         mem_burstlen,
    output logic                mem_busy,
    output logic                mem_done,
    output logic [ADDRBITS-1:0] ram_addr,
    output logic                ram_rdreq,
    output logic                ram_wrreq,
    output logic [DATABITS-1:0] ram_datain,
    input  logic                ram_ready,
    input  logic [DATABITS-1:0] ram_dataout,
    input  logic                ram_rdvalid
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_RDDRAIN, S_WR, S_DONE} state_e;

    localparam int HIBITS = ADDRBITS - CACHEADDRBITS - 2;
    localparam logic [CACHEADDRBITS:0] WORDS_C = (CACHEADDRBITS+1)'(CACHEWORDS);
    localparam logic [CACHEADDRBITS:0] LAST_C  = (CACHEADDRBITS+1)'(CACHEWORDS - 1);

    state_e                 state_q, state_d;
    logic [HIBITS-1:0]      hi_q, hi_d;
    logic [CACHEADDRBITS-1:0] idx_q, idx_d;
    logic [CACHEADDRBITS:0] iss_q, iss_d;
    logic [CACHEADDRBITS:0] ret_q, ret_d;
    logic [DATABITS-1:0]    out_q, out_d;
    logic                   valid_q, valid_d;
    logic                   ret_take;
    logic                   unused_addr_lsb;

    // Byte-offset bits of the request address carry no information for word bursts.
    assign unused_addr_lsb = ^mem_addr[1:0];

    // Next-state, address walk, counters and read-return capture.
    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        idx_d    = idx_q;
        iss_d    = iss_q;
        ret_d    = ret_q;
        out_d    = out_q;
        valid_d  = 1'b0;
        // Returns only count while a read burst is live and not yet complete;
        // anything else on ram_rdvalid is stale or spurious.
        ret_take = ((state_q == S_RD) || (state_q == S_RDDRAIN)) &&
                   ram_rdvalid && (ret_q != WORDS_C);
        if (ret_take) begin
            out_d   = ram_dataout;
            valid_d = 1'b1;
            ret_d   = ret_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (mem_wrreq || mem_rdreq) begin
                    hi_d    = mem_addr[ADDRBITS-1:CACHEADDRBITS+2];
                    idx_d   = mem_addr[CACHEADDRBITS+1:2];
                    iss_d   = '0;
                    ret_d   = '0;
                    // Write-back goes first so the fill cannot overwrite a dirty line.
                    state_d = mem_wrreq ? S_WR : S_RD;
                end
            end
            S_RD: begin
                if (ram_ready) begin
                    idx_d = idx_q + 1'b1;
                    iss_d = iss_q + 1'b1;
                    if (iss_q == LAST_C) begin
                        state_d = (ret_d == WORDS_C) ? S_DONE : S_RDDRAIN;
                    end
                end
            end
            S_RDDRAIN: begin
                if (ret_d == WORDS_C) begin
                    state_d = S_DONE;
                end
            end
            S_WR: begin
                if (ram_ready) begin
                    idx_d = idx_q + 1'b1;
                    iss_d = iss_q + 1'b1;
                    if (iss_q == LAST_C) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control state and the output data register; reset abandons any burst.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            iss_q   <= '0;
            ret_q   <= '0;
            valid_q <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            iss_q   <= iss_d;
            ret_q   <= ret_d;
            valid_q <= valid_d;
            out_q   <= out_d;
        end
    end

    // Latched line address; only observed while a command is driven.
    always_ff @(posedge clk) begin
        hi_q  <= hi_d;
        idx_q <= idx_d;
    end

    assign mem_busy     = (state_q != S_IDLE);
    assign mem_burstlen = mem_busy ? 16'(CACHEWORDS) : 16'd0;
    assign mem_done     = (state_q == S_DONE);
    assign ram_rdreq    = (state_q == S_RD);
    assign ram_wrreq    = (state_q == S_WR);
    assign ram_addr     = (ram_rdreq || ram_wrreq) ? {hi_q, idx_q, 2'b00} : '0;
    assign ram_datain   = ram_wrreq ? mem_datain : '0;
    assign mem_wrack    = ram_wrreq & ram_ready;
    assign mem_out      = out_q;
    assign mem_valid    = valid_q;

endmodule

// File: tb/tb_dcache_memctrl.sv
// Randomized scoreboard bench for dcache_memctrl: a memory responder and a
// dcache write-data feeder drive the DUT, expectations are queued per burst.
module tb_dcache_memctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] mem_addr, mem_datain, mem_out, ram_addr, ram_datain, ram_dataout;
    logic        mem_rdreq, mem_wrreq, mem_valid, mem_wrack, mem_busy, mem_done;
    logic [15:0] mem_burstlen;
    logic        ram_rdreq, ram_wrreq, ram_ready, ram_rdvalid;

    always #5 clk = ~clk;

    dcache_memctrl #(.ADDRBITS(32), .DATABITS(32), .CACHEWORDS(32), .CACHEADDRBITS(5)) dut (
        .clk(clk), .reset_n(reset_n), .mem_addr(mem_addr), .mem_rdreq(mem_rdreq),
        .mem_wrreq(mem_wrreq), .mem_datain(mem_datain), .mem_out(mem_out),
        .mem_valid(mem_valid), .mem_wrack(mem_wrack), .mem_burstlen(mem_burstlen),
        .mem_busy(mem_busy), .mem_done(mem_done), .ram_addr(ram_addr),
        .ram_rdreq(ram_rdreq), .ram_wrreq(ram_wrreq), .ram_datain(ram_datain),
        .ram_ready(ram_ready), .ram_dataout(ram_dataout), .ram_rdvalid(ram_rdvalid)
    );

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } ret_t;

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;
    logic [31:0] exp_rd_addr[$];
    logic [31:0] exp_rdata[$];
    logic [31:0] exp_wr_addr[$];
    logic [31:0] exp_wr_data[$];
    ret_t        pend[$];
    logic [31:0] wline[32];
    int wr_idx = 0;
    int done_cnt = 0, wrack_cnt = 0, rd_acc = 0, ret_deliv = 0;
    bit wr_adv = 0;
    int ready_mode = 0;
    int unsigned stall_from = 0, stall_to = 0;
    int lat_min = 2, lat_max = 2;
    bit spur = 0;
    bit extra_ret = 0;
    int extra_at = 0;
    bit prev_stalled = 0, prev_rd = 0, prev_wr = 0;
    logic [31:0] prev_addr = 0;

    // Contents of external memory at a byte address.
    function automatic logic [31:0] memval(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // i-th word address of a burst: same 128-byte line, word index wraps mod 32.
    function automatic logic [31:0] burst_addr(logic [31:0] a, int i);
        logic [31:0] w;
        w = ((a >> 2) + 32'(i)) & 32'h1F;
        return (a & ~32'h7F) | (w << 2);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_mem_out"},   mem_out, 32'h0);
        chk({tag, "_mem_valid"}, 32'(mem_valid), 32'h0);
        chk({tag, "_wrack"},     32'(mem_wrack), 32'h0);
        chk({tag, "_burstlen"},  32'(mem_burstlen), 32'h0);
        chk({tag, "_busy"},      32'(mem_busy), 32'h0);
        chk({tag, "_done"},      32'(mem_done), 32'h0);
        chk({tag, "_ram_addr"},  ram_addr, 32'h0);
        chk({tag, "_rdreq"},     32'(ram_rdreq), 32'h0);
        chk({tag, "_wrreq"},     32'(ram_wrreq), 32'h0);
        chk({tag, "_datain"},    ram_datain, 32'h0);
    endtask

    // Monitor: observes the DUT mid-cycle and pops the scoreboard queues.
    always @(negedge clk) begin
        ret_t r;
        cyc++;
        wr_adv = 1'b0;
        if (reset_n) begin
            if (prev_stalled) begin
                chk("hold_cmd", {30'b0, ram_rdreq, ram_wrreq}, {30'b0, prev_rd, prev_wr});
                chk("hold_addr", ram_addr, prev_addr);
            end
            chk("burstlen", 32'(mem_burstlen), mem_busy ? 32'd32 : 32'd0);
            chk("wrack_rule", 32'(mem_wrack), 32'(ram_wrreq & ram_ready));
            if (ram_rdreq && ram_wrreq) fail("rd_wr_both");
            if (ram_rdreq && ram_ready) begin
                if (exp_rd_addr.size() == 0) fail("rd_cmd_unexpected");
                else chk("rd_addr", ram_addr, exp_rd_addr.pop_front());
                chk("rd_after_wr", 32'(exp_wr_addr.size()), 32'd0);
                r.addr = ram_addr;
                r.due  = cyc + 32'($urandom_range(lat_max, lat_min));
                pend.push_back(r);
                rd_acc++;
            end
            if (ram_wrreq && ram_ready) begin
                if (exp_wr_addr.size() == 0) fail("wr_cmd_unexpected");
                else begin
                    chk("wr_addr", ram_addr, exp_wr_addr.pop_front());
                    chk("wr_data", ram_datain, exp_wr_data.pop_front());
                end
            end
            if (mem_wrack) begin
                wrack_cnt++;
                wr_adv = 1'b1;
            end
            if (mem_valid) begin
                if (exp_rdata.size() == 0) fail("spurious_mem_valid");
                else chk("rdata", mem_out, exp_rdata.pop_front());
            end
            if (mem_done) done_cnt++;
            prev_stalled = (ram_rdreq || ram_wrreq) && !ram_ready;
            prev_rd = ram_rdreq;
            prev_wr = ram_wrreq;
            prev_addr = ram_addr;
        end else begin
            prev_stalled = 1'b0;
        end
    end

    // Memory responder, ready pattern and dcache write-data feeder.
    always @(posedge clk) begin
        ret_t j;
        #1;
        ram_rdvalid = 1'b0;
        ram_dataout = $urandom;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            ram_rdvalid = 1'b1;
            ram_dataout = memval(pend[0].addr);
            pend.delete(0);
            ret_deliv++;
            if (extra_ret && ret_deliv == extra_at) begin
                j.addr = 32'hDEAD_0000;
                j.due  = cyc;
                pend.push_back(j);
                extra_ret = 1'b0;
            end
        end else if (spur) begin
            ram_rdvalid = 1'b1;
        end
        case (ready_mode)
            1:       ram_ready = ~ram_ready;
            2:       ram_ready = 1'($urandom_range(0, 1));
            3:       ram_ready = !(cyc >= stall_from && cyc < stall_to);
            default: ram_ready = 1'b1;
        endcase
        if (wr_adv) wr_idx++;
        mem_datain = (wr_idx < 32) ? wline[wr_idx] : $urandom;
    end

    // One or two bursts (write first when both requested), held until mem_done.
    task automatic run_burst(bit do_wr, bit do_rd, logic [31:0] addr);
        int d0, k0, nb, t;
        logic [31:0] a;
        if (do_wr) begin
            for (int i = 0; i < 32; i++) begin
                wline[i] = $urandom;
                exp_wr_addr.push_back(burst_addr(addr, i));
                exp_wr_data.push_back(wline[i]);
            end
            wr_idx = 0;
            mem_datain = wline[0];
        end
        if (do_rd) begin
            for (int i = 0; i < 32; i++) begin
                a = burst_addr(addr, i);
                exp_rd_addr.push_back(a);
                exp_rdata.push_back(memval(a));
            end
        end
        d0 = done_cnt;
        k0 = wrack_cnt;
        nb = int'(do_wr) + int'(do_rd);
        mem_addr  = addr;
        mem_wrreq = do_wr;
        mem_rdreq = do_rd;
        @(posedge clk);
        @(negedge clk);
        chk("busy_latency", 32'(mem_busy), 32'd1);
        chk("cmd_latency", 32'(do_wr ? ram_wrreq : ram_rdreq), 32'd1);
        t = 0;
        while ((done_cnt - d0) < nb && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
            if (done_cnt - d0 == 1) mem_wrreq = 1'b0;
        end
        if (t >= 3000) fail("burst_timeout");
        mem_wrreq = 1'b0;
        mem_rdreq = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("done_count", 32'(done_cnt - d0), 32'(nb));
        if (do_wr) chk("wrack_count", 32'(wrack_cnt - k0), 32'd32);
        chk("rd_cmds_left", 32'(exp_rd_addr.size()), 32'd0);
        chk("rdata_left", 32'(exp_rdata.size()), 32'd0);
        chk("wr_cmds_left", 32'(exp_wr_addr.size()), 32'd0);
        chk("idle_after", 32'(mem_busy), 32'd0);
    endtask

    initial begin
        int d0, a0, t, op;
        reset_n = 1'b0;
        mem_addr = '0; mem_rdreq = 1'b0; mem_wrreq = 1'b0; mem_datain = '0;
        ram_ready = 1'b1; ram_dataout = '0; ram_rdvalid = 1'b0;
        for (int i = 0; i < 32; i++) wline[i] = '0;
        wr_idx = 32;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Critical-word-first read, returns ~3 cycles after issue.
        run_burst(1'b0, 1'b1, 32'h0000_1048);

        // Write with ram_ready alternating.
        ready_mode = 1;
        run_burst(1'b1, 1'b0, 32'h0000_2000);
        ready_mode = 0;

        // Simultaneous requests: write-back then fill of the same line.
        run_burst(1'b1, 1'b1, 32'h0000_3064);

        // Reset after ten read issues; late returns must not surface.
        for (int i = 0; i < 32; i++) begin
            exp_rd_addr.push_back(burst_addr(32'h0000_5010, i));
            exp_rdata.push_back(memval(burst_addr(32'h0000_5010, i)));
        end
        d0 = done_cnt;
        a0 = rd_acc;
        mem_addr = 32'h0000_5010;
        mem_rdreq = 1'b1;
        t = 0;
        while ((rd_acc - a0) < 10 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 500) fail("reset_test_timeout");
        reset_n = 1'b0;
        mem_rdreq = 1'b0;
        @(posedge clk);
        #1;
        exp_rd_addr.delete();
        exp_rdata.delete();
        @(negedge clk);
        chk_zero("midburst_reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("reset_no_done", 32'(done_cnt - d0), 32'd0);
        chk("reset_idle", 32'(mem_busy), 32'd0);

        // Spurious returns while idle, then a 33rd return right after a burst.
        spur = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        spur = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("spur_idle", 32'(mem_busy), 32'd0);
        lat_min = 1;
        lat_max = 4;
        extra_at = ret_deliv + 32;
        extra_ret = 1'b1;
        run_burst(1'b0, 1'b1, 32'h0000_6078);
        extra_ret = 1'b0;

        // Long ram_ready stall in the middle of a read.
        lat_min = 2;
        lat_max = 2;
        stall_from = cyc + 12;
        stall_to = stall_from + 20;
        ready_mode = 3;
        run_burst(1'b0, 1'b1, 32'h0000_7004);
        ready_mode = 0;

        // Random bursts with random ready and return latency.
        for (int n = 0; n < 8; n++) begin
            ready_mode = 2;
            lat_min = 0;
            lat_max = $urandom_range(0, 6);
            op = $urandom_range(0, 2);
            run_burst(op != 1, op != 0, $urandom);
        end
        ready_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
